// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet header prepender: header length,
// FSM encoding and the header byte selector.
package eth_pkg;

  localparam logic [3:0] ETH_HDR_LEN = 4'd14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } eth_state_e;

  // Header is {dest, src, type}; byte 0 is the most significant byte on the wire.
  function automatic logic [7:0] hdr_byte(input logic [111:0] hdr, input logic [3:0] idx);
    logic [111:0] shifted;
    shifted = hdr << {idx, 3'b000};
    return shifted[111:104];
  endfunction

endpackage

// File: rtl/eth_axis_hdr_tx_if.sv
// Bus bundles for the header prepender: header field handshake and an
// 8-bit AXI stream with last/user sidebands.
interface eth_hdr_if;
  logic        valid;
  logic        ready;
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;

  modport master (output valid, output dest_mac, output src_mac, output eth_type, input ready);
  modport slave  (input valid, input dest_mac, input src_mac, input eth_type, output ready);
endinterface

interface axis8_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_skid_out.sv
// Two-entry output skid buffer (output register + temp register) with a
// registered upstream ready, so m_axis never sees a combinational path.
module axis_skid_out (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_tdata,
  input  logic       in_tvalid,
  input  logic       in_tlast,
  input  logic       in_tuser,
  output logic       in_tready,
  axis8_if.master    m_axis
);

  logic [7:0] out_data_r;
  logic       out_valid_r;
  logic       out_last_r;
  logic       out_user_r;
  logic [7:0] tmp_data_r;
  logic       tmp_valid_r;
  logic       tmp_last_r;
  logic       tmp_user_r;
  logic       ready_r;
  logic       ready_next_s;

  // Ready for next cycle: free slot is guaranteed unless both stages could fill.
  always_comb begin
    ready_next_s = m_axis.tready || (!tmp_valid_r && (!out_valid_r || !in_tvalid));
  end

  // Skid storage: input goes to output when it can move, else parks in temp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r     <= 1'b0;
      out_data_r  <= 8'd0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_user_r  <= 1'b0;
      tmp_data_r  <= 8'd0;
      tmp_valid_r <= 1'b0;
      tmp_last_r  <= 1'b0;
      tmp_user_r  <= 1'b0;
    end else begin
      ready_r <= ready_next_s;
      if (ready_r) begin
        if (m_axis.tready || !out_valid_r) begin
          out_data_r  <= in_tdata;
          out_valid_r <= in_tvalid;
          out_last_r  <= in_tlast;
          out_user_r  <= in_tuser;
        end else begin
          tmp_data_r  <= in_tdata;
          tmp_valid_r <= in_tvalid;
          tmp_last_r  <= in_tlast;
          tmp_user_r  <= in_tuser;
        end
      end else if (m_axis.tready) begin
        out_data_r  <= tmp_data_r;
        out_valid_r <= tmp_valid_r;
        out_last_r  <= tmp_last_r;
        out_user_r  <= tmp_user_r;
        tmp_valid_r <= 1'b0;
      end
    end
  end

  assign in_tready     = ready_r;
  assign m_axis.tdata  = out_data_r;
  assign m_axis.tvalid = out_valid_r;
  assign m_axis.tlast  = out_last_r;
  assign m_axis.tuser  = out_user_r;

endmodule

// File: rtl/eth_axis_hdr_tx.sv
// Ethernet header prepender: emits the 14-byte MAC header from latched
// fields, then forwards the payload stream, through an output skid buffer.
module eth_axis_hdr_tx
  import eth_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  eth_hdr_if.slave  s_eth_hdr,
  axis8_if.slave    s_eth_payload_axis,
  axis8_if.master   m_axis,
  output logic      busy
);

  eth_state_e     state_r;
  eth_state_e     state_next_s;
  logic [3:0]     ptr_r;
  logic [3:0]     ptr_next_s;
  logic [111:0]   hdr_r;
  logic           busy_r;
  logic           busy_next_s;
  logic           latch_s;
  logic           hdr_ready_s;
  logic           pay_ready_s;
  logic [7:0]     int_data_s;
  logic           int_valid_s;
  logic           int_last_s;
  logic           int_user_s;
  logic           int_ready_s;

  // Next-state and datapath selection for the header/payload sequencer.
  always_comb begin
    state_next_s = state_r;
    ptr_next_s   = ptr_r;
    busy_next_s  = busy_r;
    latch_s      = 1'b0;
    hdr_ready_s  = 1'b0;
    pay_ready_s  = 1'b0;
    int_data_s   = 8'd0;
    int_valid_s  = 1'b0;
    int_last_s   = 1'b0;
    int_user_s   = 1'b0;
    case (state_r)
      IDLE: begin
        hdr_ready_s = int_ready_s;
        // Byte 0 comes straight from the inputs; the latch lands on this edge.
        if (s_eth_hdr.valid && int_ready_s) begin
          latch_s      = 1'b1;
          int_valid_s  = 1'b1;
          int_data_s   = s_eth_hdr.dest_mac[47:40];
          ptr_next_s   = 4'd1;
          busy_next_s  = 1'b1;
          state_next_s = HEADER;
        end else begin
          state_next_s = IDLE;
        end
      end
      HEADER: begin
        if (int_ready_s) begin
          int_valid_s = 1'b1;
          int_data_s  = hdr_byte(hdr_r, ptr_r);
          if (ptr_r == ETH_HDR_LEN - 4'd1) begin
            ptr_next_s   = 4'd0;
            state_next_s = PAYLOAD;
          end else begin
            ptr_next_s   = ptr_r + 4'd1;
          end
        end else begin
          state_next_s = HEADER;
        end
      end
      PAYLOAD: begin
        pay_ready_s = int_ready_s;
        if (s_eth_payload_axis.tvalid && int_ready_s) begin
          int_valid_s = 1'b1;
          int_data_s  = s_eth_payload_axis.tdata;
          int_last_s  = s_eth_payload_axis.tlast;
          int_user_s  = s_eth_payload_axis.tuser;
          if (s_eth_payload_axis.tlast) begin
            busy_next_s  = 1'b0;
            state_next_s = IDLE;
          end else begin
            state_next_s = PAYLOAD;
          end
        end else begin
          state_next_s = PAYLOAD;
        end
      end
      default: begin
        state_next_s = IDLE;
        ptr_next_s   = 4'd0;
        busy_next_s  = 1'b0;
      end
    endcase
  end

  // Sequencer state, header pointer and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ptr_r   <= 4'd0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
      busy_r  <= busy_next_s;
    end
  end

  // Header fields captured on the accept edge; upstream may change them afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_r <= 112'd0;
    end else if (latch_s) begin
      hdr_r <= {s_eth_hdr.dest_mac, s_eth_hdr.src_mac, s_eth_hdr.eth_type};
    end
  end

  assign s_eth_hdr.ready          = hdr_ready_s;
  assign s_eth_payload_axis.tready = pay_ready_s;
  assign busy                     = busy_r;

  axis_skid_out u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_tdata  (int_data_s),
    .in_tvalid (int_valid_s),
    .in_tlast  (int_last_s),
    .in_tuser  (int_user_s),
    .in_tready (int_ready_s),
    .m_axis    (m_axis)
  );

endmodule

// File: tb/tb_eth_axis_hdr_tx.sv
// Randomized bench for eth_axis_hdr_tx against a byte-queue model of the
// frame format (header MSB-first, then payload) plus timing rules.
module tb_eth_axis_hdr_tx;

  typedef struct { logic [47:0] d; logic [47:0] s; logic [15:0] t; } hdr_t;
  typedef struct { logic [7:0] data; logic last; logic user; } pay_t;
  typedef struct { logic [7:0] data; logic last; logic user; int idx; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  eth_hdr_if hdr_if ();
  axis8_if   pay_if ();
  axis8_if   m_if ();

  eth_axis_hdr_tx dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .s_eth_hdr          (hdr_if),
    .s_eth_payload_axis (pay_if),
    .m_axis             (m_if),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  int   err_cnt = 0;
  int   chk_cnt = 0;
  hdr_t hdr_q[$];
  pay_t pay_q[$];
  exp_t exp_q[$];
  bit   in_frame = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic add_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    logic [7:0] b;
    hdr_q.push_back('{d, s, t});
    for (int i = 0; i < 14; i++) begin
      if (i < 6)       b = 8'(d >> (8 * (5 - i)));
      else if (i < 12) b = 8'(s >> (8 * (11 - i)));
      else             b = 8'(t >> (8 * (13 - i)));
      exp_q.push_back('{b, 1'b0, 1'b0, i});
    end
  endtask

  task automatic add_pay(input logic [7:0] data, input logic last, input logic user, input int idx);
    pay_q.push_back('{data, last, user});
    exp_q.push_back('{data, last, user, 14 + idx});
  endtask

  task automatic rand_frame(input int len);
    add_frame({16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)}, 16'($urandom));
    for (int i = 0; i < len; i++)
      add_pay(8'($urandom), (i == len - 1), ($urandom_range(0, 7) == 0), i);
  endtask

  task automatic drive(input int rmode, input bit full);
    hdr_if.valid = (hdr_q.size() > 0) && (full || $urandom_range(0, 3) != 0);
    if (hdr_if.valid) begin
      hdr_if.dest_mac = hdr_q[0].d;
      hdr_if.src_mac  = hdr_q[0].s;
      hdr_if.eth_type = hdr_q[0].t;
    end else begin
      hdr_if.dest_mac = {16'($urandom), 32'($urandom)};
      hdr_if.src_mac  = {16'($urandom), 32'($urandom)};
      hdr_if.eth_type = 16'($urandom);
    end
    pay_if.tvalid = (pay_q.size() > 0) && (full || $urandom_range(0, 3) != 0);
    if (pay_if.tvalid) begin
      pay_if.tdata = pay_q[0].data;
      pay_if.tlast = pay_q[0].last;
      pay_if.tuser = pay_q[0].user;
    end else begin
      pay_if.tdata = 8'($urandom);
      pay_if.tlast = 1'($urandom);
      pay_if.tuser = 1'($urandom);
    end
    case (rmode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = ~m_if.tready;
      default: m_if.tready = ($urandom_range(0, 2) != 0);
    endcase
  endtask

  task automatic run(input int rmode, input bit full, input int max_cyc, input bit stop5);
    bit   strict, stop, started, prev_tl, lat_pending, hf, pf, of;
    int   gaps, cyc;
    exp_t e;
    strict = full && (rmode == 0);
    stop = 0; started = 0; prev_tl = 0; lat_pending = 0; gaps = 0; cyc = 0;
    drive(rmode, full);
    while (exp_q.size() > 0 && !stop && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      hf = hdr_if.valid && hdr_if.ready;
      pf = pay_if.tvalid && pay_if.tready;
      of = m_if.tvalid && m_if.tready;
      check_eq("busy", 32'(busy), 32'(in_frame));
      if (!in_frame) check_eq("pay_rdy_idle", 32'(pay_if.tready), 32'd0);
      if (in_frame)  check_eq("hdr_rdy_busy", 32'(hdr_if.ready), 32'd0);
      if (lat_pending) check_eq("lat_byte0", 32'(m_if.tvalid), 32'd1);
      if (m_if.tvalid) begin
        e = exp_q[0];
        if (e.idx <= 12) check_eq("pay_rdy_hdr", 32'(pay_if.tready), 32'd0);
        if (stop5 && e.idx == 5) stop = 1;
        if (of) begin
          check_eq("tdata", 32'(m_if.tdata), 32'(e.data));
          check_eq("tlast", 32'(m_if.tlast), 32'(e.last));
          check_eq("tuser", 32'(m_if.tuser), 32'(e.user));
          if (strict && e.idx == 13) check_eq("pay_at_b13", 32'(pf), 32'd1);
          void'(exp_q.pop_front());
        end
      end
      if (strict && started && !m_if.tvalid && exp_q.size() > 0) gaps++;
      if (m_if.tvalid) started = 1;
      if (strict && prev_tl && hdr_q.size() > 0) check_eq("hdr_rdy_b2b", 32'(hdr_if.ready), 32'd1);
      prev_tl = pf && pay_if.tlast;
      lat_pending = hf;
      if (!stop) begin
        @(posedge clk);
        #1;
        if (hf) begin
          void'(hdr_q.pop_front());
          in_frame = 1'b1;
        end
        if (pf) begin
          if (pay_q[0].last) in_frame = 1'b0;
          void'(pay_q.pop_front());
        end
        drive(rmode, full);
      end
    end
    if (stop5) check_eq("reached_b5", 32'(stop), 32'd1);
    else       check_eq("drain", 32'(exp_q.size()), 32'd0);
    if (strict) check_eq("gaps", 32'(gaps), 32'd0);
  endtask

  initial begin
    hdr_if.valid = 1'b0; hdr_if.dest_mac = 48'd0; hdr_if.src_mac = 48'd0; hdr_if.eth_type = 16'd0;
    pay_if.tvalid = 1'b0; pay_if.tdata = 8'd0; pay_if.tlast = 1'b0; pay_if.tuser = 1'b0;
    m_if.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    check_eq("rst_tlast", 32'(m_if.tlast), 32'd0);
    check_eq("rst_tuser", 32'(m_if.tuser), 32'd0);
    check_eq("rst_tdata", 32'(m_if.tdata), 32'd0);
    check_eq("rst_pay_rdy", 32'(pay_if.tready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_hdr_rdy", 32'(hdr_if.ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("hdr_rdy_pre_edge", 32'(hdr_if.ready), 32'd0);
    @(posedge clk);
    #1 check_eq("hdr_rdy_post_rst", 32'(hdr_if.ready), 32'd1);

    // Reference frame at full rate, then with tready toggling.
    add_frame(48'h02_00_00_00_00_01, 48'h5A_51_52_53_54_55, 16'h0800);
    add_pay(8'hAA, 1'b0, 1'b0, 0); add_pay(8'hBB, 1'b0, 1'b0, 1); add_pay(8'hCC, 1'b1, 1'b0, 2);
    run(0, 1'b1, 200, 1'b0);
    add_frame(48'h02_00_00_00_00_01, 48'h5A_51_52_53_54_55, 16'h0800);
    add_pay(8'hAA, 1'b0, 1'b0, 0); add_pay(8'hBB, 1'b0, 1'b0, 1); add_pay(8'hCC, 1'b1, 1'b0, 2);
    run(1, 1'b1, 200, 1'b0);

    // Error marker on the final byte.
    rand_frame(0);
    add_pay(8'h01, 1'b0, 1'b0, 0); add_pay(8'h02, 1'b1, 1'b1, 1);
    run(0, 1'b1, 200, 1'b0);

    // Back-to-back frames, then a randomized soak.
    rand_frame(1 + $urandom_range(0, 6));
    rand_frame(1 + $urandom_range(0, 6));
    rand_frame(1);
    run(0, 1'b1, 500, 1'b0);
    for (int i = 0; i < 25; i++) rand_frame($urandom_range(1, 16));
    run(2, 1'b0, 20000, 1'b0);

    // Reset while header byte 5 sits on the output.
    rand_frame(4);
    run(0, 1'b1, 200, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_tvalid", 32'(m_if.tvalid), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_pay_rdy", 32'(pay_if.tready), 32'd0);
    hdr_q.delete(); pay_q.delete(); exp_q.delete();
    in_frame = 1'b0;
    hdr_if.valid = 1'b0; pay_if.tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_eq("hdr_rdy_after_rst", 32'(hdr_if.ready), 32'd1);
    rand_frame(5);
    run(0, 1'b1, 200, 1'b0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
